// File: rtl/gapu_mv_operand_bank.sv
// Operand/result memory for the GAPU v1 core: host loads A and B, the core reads them
// and writes C, and the bank drains C back to the host once the core signals done.
module gapu_mv_operand_bank #(
  parameter int unsigned GA_DIM  = 32,
  parameter int unsigned BLADE_W = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               core_start,
  input  logic               core_done,
  input  logic [BLADE_W-1:0] addr_a,
  output logic [DATA_W-1:0]  data_a,
  input  logic [BLADE_W-1:0] addr_b,
  output logic [DATA_W-1:0]  data_b,
  input  logic [BLADE_W-1:0] addr_c,
  input  logic [DATA_W-1:0]  data_c,
  input  logic               wen_c,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_last,
  output logic               err_wr,
  output logic               err_incomplete,
  output logic               bank_busy
);

  localparam int unsigned LD_W    = $clog2(2 * GA_DIM);
  localparam int unsigned LD_LAST = 2 * GA_DIM - 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state;
  logic [LD_W-1:0]    ld_cnt;
  logic [BLADE_W-1:0] rd_idx;
  logic [GA_DIM-1:0]  wmask;
  logic [GA_DIM-1:0]  wmask_upd;
  logic [BLADE_W-1:0] ld_idx;
  logic               ld_is_a;
  logic               ld_fire;
  logic               rd_fire;
  logic               run_wr;

  logic [DATA_W-1:0] mem_a [GA_DIM];
  logic [DATA_W-1:0] mem_b [GA_DIM];
  logic [DATA_W-1:0] mem_c [GA_DIM];

  // Handshake-facing flags decode straight from the state register.
  assign ld_ready   = (state == S_LOAD);
  assign core_start = (state == S_START);
  assign rd_valid   = (state == S_DRAIN);
  assign bank_busy  = (state != S_LOAD);

  assign ld_fire = ld_valid && ld_ready;
  assign rd_fire = rd_valid && rd_ready;
  assign run_wr  = wen_c && (state == S_RUN);

  assign rd_last = rd_valid && (rd_idx == BLADE_W'(GA_DIM - 1));
  assign rd_data = rd_valid ? mem_c[rd_idx] : '0;

  assign ld_is_a = (ld_cnt < LD_W'(GA_DIM));
  assign ld_idx  = ld_is_a ? BLADE_W'(ld_cnt) : BLADE_W'(ld_cnt - LD_W'(GA_DIM));

  // Mask as it would be after this cycle's writeback, so a write coincident with done counts.
  assign wmask_upd = wmask | (wen_c ? (GA_DIM'(1) << addr_c) : '0);

  // Job sequencer, counters and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_LOAD;
      ld_cnt         <= '0;
      rd_idx         <= '0;
      wmask          <= '0;
      err_wr         <= 1'b0;
      err_incomplete <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (wen_c) err_wr <= 1'b1;
          if (ld_fire) begin
            if (ld_cnt == LD_W'(LD_LAST)) begin
              ld_cnt <= '0;
              state  <= S_START;
            end else begin
              ld_cnt <= ld_cnt + LD_W'(1);
            end
          end
        end
        S_START: begin
          wmask          <= '0;
          err_wr         <= wen_c;
          err_incomplete <= 1'b0;
          state          <= S_RUN;
        end
        S_RUN: begin
          if (wen_c) wmask <= wmask_upd;
          if (core_done) begin
            if (~&wmask_upd) err_incomplete <= 1'b1;
            rd_idx <= '0;
            state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wen_c) err_wr <= 1'b1;
          if (rd_fire) begin
            rd_idx <= rd_idx + BLADE_W'(1);
            if (rd_last) state <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Storage arrays carry no reset; contents are only meaningful after a load or run.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      if (ld_is_a) mem_a[ld_idx] <= ld_data;
      else         mem_b[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_START) begin
      for (int unsigned i = 0; i < GA_DIM; i++) mem_c[i] <= '0;
    end else if (run_wr) begin
      mem_c[addr_c] <= data_c;
    end
  end

  // Core read ports: fixed one-cycle latency in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= mem_a[addr_a];
      data_b <= mem_b[addr_b];
    end
  end

endmodule

// File: tb/tb_gapu_mv_operand_bank.sv
// Randomized job-level bench for gapu_mv_operand_bank against a simple array/queue model.
module tb_gapu_mv_operand_bank;

  localparam int unsigned GA_DIM  = 32;
  localparam int unsigned BLADE_W = 5;
  localparam int unsigned DATA_W  = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ld_valid;
  logic               ld_ready;
  logic [DATA_W-1:0]  ld_data;
  logic               core_start;
  logic               core_done;
  logic [BLADE_W-1:0] addr_a;
  logic [DATA_W-1:0]  data_a;
  logic [BLADE_W-1:0] addr_b;
  logic [DATA_W-1:0]  data_b;
  logic [BLADE_W-1:0] addr_c;
  logic [DATA_W-1:0]  data_c;
  logic               wen_c;
  logic               rd_valid;
  logic               rd_ready;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_last;
  logic               err_wr;
  logic               err_incomplete;
  logic               bank_busy;

  gapu_mv_operand_bank #(.GA_DIM(GA_DIM), .BLADE_W(BLADE_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .core_start(core_start), .core_done(core_done),
    .addr_a(addr_a), .data_a(data_a), .addr_b(addr_b), .data_b(data_b),
    .addr_c(addr_c), .data_c(data_c), .wen_c(wen_c),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .err_wr(err_wr), .err_incomplete(err_incomplete), .bank_busy(bank_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ma [GA_DIM];
  logic [31:0] mb [GA_DIM];
  logic [31:0] mc [GA_DIM];
  bit          written [GA_DIM];
  bit          exp_err_wr;
  bit          exp_err_inc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit pattern, input bit gappy);
    int n;
    int budget;
    for (int k = 0; k < 32; k++) begin
      ma[k] = pattern ? 32'(k + 1)        : $urandom;
      mb[k] = pattern ? 32'(32'h100 + k)  : $urandom;
    end
    n = 0;
    budget = 0;
    while (n < 64 && budget < 1000) begin
      check("ld_ready_load", 32'(ld_ready), 32'd1);
      ld_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_data  = (n < 32) ? ma[n] : mb[n-32];
      step();
      if (ld_valid) n++;
      budget++;
    end
    ld_valid = 1'b0;
    ld_data  = '0;
    check("ld_count", 32'(n), 32'd64);
    check("ld_ready_drop", 32'(ld_ready), 32'd0);
    check("core_start_hi", 32'(core_start), 32'd1);
    check("busy_start", 32'(bank_busy), 32'd1);
    check("err_wr_pre_start", 32'(err_wr), 32'(exp_err_wr));
    for (int k = 0; k < 32; k++) begin
      mc[k] = '0;
      written[k] = 1'b0;
    end
    exp_err_wr  = 1'b0;
    exp_err_inc = 1'b0;
    step();
    check("core_start_pulse", 32'(core_start), 32'd0);
    check("err_wr_cleared", 32'(err_wr), 32'd0);
    check("err_inc_cleared", 32'(err_incomplete), 32'd0);
    check("busy_run", 32'(bank_busy), 32'd1);
  endtask

  task automatic do_reads(input int n, input bit directed);
    int a;
    int b;
    for (int i = 0; i < n; i++) begin
      a = (directed && i == 0) ? 5  : int'($urandom_range(0, 31));
      b = (directed && i == 0) ? 31 : int'($urandom_range(0, 31));
      addr_a = BLADE_W'(a);
      addr_b = BLADE_W'(b);
      step();
      check("data_a", data_a, ma[a]);
      check("data_b", data_b, mb[b]);
    end
  endtask

  task automatic core_write(input int addr, input logic [31:0] data);
    wen_c  = 1'b1;
    addr_c = BLADE_W'(addr);
    data_c = data;
    mc[addr] = data;
    written[addr] = 1'b1;
  endtask

  // mode 0: full C[k]=0xC000+k; mode 1: C[0..15]=0xAA; mode 2: random writes, one with done
  task automatic do_run(input int mode);
    int nw;
    bit full;
    nw = (mode == 2) ? int'($urandom_range(20, 70)) : ((mode == 1) ? 16 : 32);
    for (int i = 0; i < nw; i++) begin
      if (mode == 0)      core_write(i, 32'(32'hC000 + i));
      else if (mode == 1) core_write(i, 32'hAA);
      else                core_write(int'($urandom_range(0, 31)), $urandom);
      step();
      wen_c = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end
    check("rd_valid_run", 32'(rd_valid), 32'd0);
    if (mode == 2) core_write(int'($urandom_range(0, 31)), $urandom);
    core_done = 1'b1;
    full = 1'b1;
    for (int k = 0; k < 32; k++) if (!written[k]) full = 1'b0;
    exp_err_inc = !full;
    step();
    core_done = 1'b0;
    wen_c     = 1'b0;
    check("rd_valid_drain", 32'(rd_valid), 32'd1);
    check("err_incomplete", 32'(err_incomplete), 32'(exp_err_inc));
  endtask

  // mode 0: always ready; 1: ready 1,0,0,1 repeating; 2: random. abort_at<0 means no reset.
  task automatic do_drain(input int mode, input int abort_at);
    int beat;
    int cyc;
    beat = 0;
    cyc  = 0;
    while (beat < 32 && cyc < 500) begin
      if (mode == 0)      rd_ready = 1'b1;
      else if (mode == 1) rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else                rd_ready = $urandom_range(0, 1) != 0;
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_data", rd_data, mc[beat]);
      check("rd_last", 32'(rd_last), 32'(beat == 31));
      if (beat == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_busy", 32'(bank_busy), 32'd0);
        rd_ready = 1'b0;
        exp_err_wr  = 1'b0;
        exp_err_inc = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ld_ready", 32'(ld_ready), 32'd1);
        check("post_rst_err_inc", 32'(err_incomplete), 32'd0);
        return;
      end
      step();
      if (rd_ready) beat++;
      cyc++;
    end
    rd_ready = 1'b0;
    check("drain_beats", 32'(beat), 32'd32);
    check("rd_valid_end", 32'(rd_valid), 32'd0);
    check("ld_ready_after_drain", 32'(ld_ready), 32'd1);
    check("busy_after_drain", 32'(bank_busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_data = '0; core_done = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0; data_c = '0; wen_c = 1'b0; rd_ready = 1'b0;
    exp_err_wr = 1'b0; exp_err_inc = 1'b0;
    repeat (3) step();
    check("reset_ld_ready", 32'(ld_ready), 32'd1);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_core_start", 32'(core_start), 32'd0);
    check("reset_busy", 32'(bank_busy), 32'd0);
    check("reset_err_wr", 32'(err_wr), 32'd0);
    check("reset_err_inc", 32'(err_incomplete), 32'd0);
    check("reset_rd_last", 32'(rd_last), 32'd0);
    check("reset_data_a", data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Stray core traffic while loading: write flags an error, done is ignored.
    wen_c = 1'b1; addr_c = 5'd3; data_c = 32'hDEAD;
    step();
    wen_c = 1'b0;
    exp_err_wr = 1'b1;
    check("err_wr_set", 32'(err_wr), 32'd1);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("done_ignored_ld_ready", 32'(ld_ready), 32'd1);
    check("done_ignored_busy", 32'(bank_busy), 32'd0);

    do_load(1'b1, 1'b0);
    do_reads(4, 1'b1);
    do_run(0);
    do_drain(0, -1);

    do_load(1'b0, 1'b1);
    do_reads(6, 1'b0);
    do_run(1);
    do_drain(1, -1);

    do_load(1'b0, 1'b1);
    do_reads(6, 1'b0);
    do_run(2);
    do_drain(2, -1);

    do_load(1'b0, 1'b0);
    do_run(0);
    do_drain(0, 10);

    do_load(1'b0, 1'b1);
    do_reads(6, 1'b0);
    do_run(2);
    do_drain(1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gapu_mv_operand_bank.md
Name: gapu_mv_operand_bank

Overview:
- Memory-side responder for the GAPU v1 core's operand/result interface.
- A host streams in multivectors A and B. The bank then:
  - serves the core's A[i]/B[j] address-based reads with fixed 1-cycle latency;
  - captures the core's C writeback stream;
  - drains C back to the host over a valid/ready stream.
- It sequences the whole job: load, start core, wait for done, drain.

Parameters:
- GA_DIM, 32, number of basis blades per multivector.
- BLADE_W, 5, blade index width (log2 GA_DIM).
- DATA_W, 32, coefficient width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- ld_valid  in  1  host load word valid.
- ld_ready  out  1  bank accepts load word (high only in S_LOAD).
- ld_data  in  DATA_W  load word: A[0..GA_DIM-1], then B[0..GA_DIM-1].
- core_start  out  1  one-cycle start pulse to core.
- core_done  in  1  core completion pulse.
- addr_a  in  BLADE_W  core read address, bank A.
- data_a  out  DATA_W  A[addr_a], registered.
- addr_b  in  BLADE_W  core read address, bank B.
- data_b  out  DATA_W  B[addr_b], registered.
- addr_c  in  BLADE_W  core writeback address.
- data_c  in  DATA_W  core writeback data.
- wen_c  in  1  core writeback strobe.
- rd_valid  out  1  result word valid.
- rd_ready  in  1  host accepts result word.
- rd_data  out  DATA_W  C[rd index].
- rd_last  out  1  marks C[GA_DIM-1].
- err_wr  out  1  sticky: wen_c seen outside S_RUN.
- err_incomplete  out  1  sticky: core_done before every C blade was written.
- bank_busy  out  1  high in S_START, S_RUN, S_DRAIN.

Behaviour:
- Storage:
  - three GA_DIM x DATA_W arrays A, B, C;
  - GA_DIM-bit written mask wmask;
  - load counter ld_cnt (0..2*GA_DIM-1);
  - drain index rd_idx (BLADE_W bits).
- Reset:
  - state=S_LOAD; ld_cnt=0; rd_idx=0; wmask=0.
  - All outputs 0, except ld_ready=1 after reset (it is combinational from state).
  - Array contents are not reset.
- S_LOAD:
  - ld_ready=1. A word is taken on ld_valid&&ld_ready.
  - ld_cnt<GA_DIM writes A[ld_cnt]; otherwise writes B[ld_cnt-GA_DIM].
  - ld_valid low stalls with no state change.
  - The handshake at ld_cnt=2*GA_DIM-1 sets ld_cnt=0 and moves to S_START.
- S_START (1 cycle):
  - core_start=1; C cleared to 0; wmask=0; next state S_RUN.
  - core_start is high for exactly this one cycle.
- S_RUN:
  - wen_c writes C[addr_c]=data_c and sets wmask[addr_c]. Duplicate writes: last wins.
  - On core_done: set err_incomplete if wmask (including a same-cycle write) is not all-ones, then go to S_DRAIN with rd_idx=0.
  - A wen_c in the core_done cycle is still captured.
- S_DRAIN:
  - rd_valid=1; rd_data=C[rd_idx]; rd_last=(rd_idx==GA_DIM-1).
  - A transfer on rd_valid&&rd_ready advances rd_idx.
  - While rd_ready=0, rd_data/rd_last hold stable.
  - The transfer with rd_last=1 goes to S_LOAD; ld_ready=1 on the next cycle.
- Reads:
  - data_a<=A[addr_a] and data_b<=B[addr_b] every cycle in every state.
  - Latency: 1 cycle from address to data. Both ports read independently in the same cycle.
- Errors:
  - wen_c outside S_RUN is ignored (C unchanged) and sets err_wr.
  - core_done outside S_RUN is ignored.
  - err_wr and err_incomplete clear only on the next S_START or on reset.
- Reset mid-operation: all of the above reset values apply immediately (asynchronous); any partial load or drain is discarded.
- Arithmetic: none on data. All counters are exact-width. ld_cnt never exceeds 2*GA_DIM-1.

Test Plan:
- Load A[k]=k+1 and B[k]=0x100+k with ld_valid held high:
  - ld_ready drops after the 64th handshake;
  - core_start is high for exactly 1 cycle on the next cycle;
  - addr_a=5 gives data_a=6 one cycle later; addr_b=31 gives data_b=0x11F.
- In S_RUN, write C[k]=0xC000+k for k=0..31, then pulse core_done; drain with rd_ready=1:
  - 32 beats 0xC000..0xC01F;
  - rd_last only on beat 31;
  - err_incomplete=0; ld_ready=1 the cycle after the last beat.
- Drain with rd_ready toggling 1,0,0,1 repeatedly: rd_data stable while stalled; exactly 32 beats, no duplicates or skips.
- Write only C[0..15]=0xAA, then core_done: err_incomplete=1; drain gives 0xAA x16 then 0 x16.
- Pulse wen_c with addr_c=3, data_c=0xDEAD during S_LOAD: err_wr=1; the later drain shows C[3] = the value written in S_RUN, not 0xDEAD.
- Assert rst_n=0 at drain beat 10: rd_valid=0 and core_start=0 immediately; after release ld_ready=1 and a fresh 64-word load completes normally.
